// File: rtl/sdcmd_responder_if.sv
// rtl/sdcmd_responder_if.sv - SD CMD-line responder bus bundle
// Groups everything except clock and reset:
//   CMD line      : i_ck_en (SD-clock strobe), i_cmd (line in), o_cmd_oe / o_cmd (line drive)
//   command report: o_cmd_valid, o_cmd_idx, o_cmd_arg, o_cmd_crcerr
//   response in   : i_rsp_valid / o_rsp_ready handshake, i_rsp_none, i_rsp_idx, i_rsp_arg
//   status        : o_rsp_drop (response window abandoned), o_busy
// slave = the responder, master = whoever feeds the line and answers commands.
interface sdcmd_responder_if;
    logic        i_ck_en;
    logic        i_cmd;
    logic        o_cmd_oe;
    logic        o_cmd;
    logic        o_cmd_valid;
    logic [5:0]  o_cmd_idx;
    logic [31:0] o_cmd_arg;
    logic        o_cmd_crcerr;
    logic        i_rsp_valid;
    logic        o_rsp_ready;
    logic        i_rsp_none;
    logic [5:0]  i_rsp_idx;
    logic [31:0] i_rsp_arg;
    logic        o_rsp_drop;
    logic        o_busy;

    modport slave (
        input  i_ck_en, i_cmd, i_rsp_valid, i_rsp_none, i_rsp_idx, i_rsp_arg,
        output o_cmd_oe, o_cmd, o_cmd_valid, o_cmd_idx, o_cmd_arg, o_cmd_crcerr,
               o_rsp_ready, o_rsp_drop, o_busy
    );

    modport master (
        output i_ck_en, i_cmd, i_rsp_valid, i_rsp_none, i_rsp_idx, i_rsp_arg,
        input  o_cmd_oe, o_cmd, o_cmd_valid, o_cmd_idx, o_cmd_arg, o_cmd_crcerr,
               o_rsp_ready, o_rsp_drop, o_busy
    );
endinterface

// File: rtl/sdcmd_responder.sv
// rtl/sdcmd_responder.sv - SD device-side CMD receiver and 48-bit response transmitter
// Ports: i_clk, i_reset_n (async, active low), bus (sdcmd_responder_if.slave).
// Receives 48-bit host commands on i_cmd (sampled on i_ck_en strobes), checks CRC7,
// reports them, waits for a response decision and drives the response NCR strobes
// after the command end bit. Gives up waiting after NCR_MAX strobes.
module sdcmd_responder #(
    parameter int NCR     = 2,
    parameter int NCR_MAX = 64
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    sdcmd_responder_if.slave      bus
);
    localparam int CW = $clog2(NCR_MAX + 1);
    localparam logic [CW-1:0] NCR_C = CW'(NCR);
    localparam logic [CW-1:0] MAX_C = CW'(NCR_MAX);

    typedef enum logic [2:0] {IDLE, RXCMD, RSPWAIT, GAP, TXRSP} state_t;

    state_t        state;
    logic [47:0]   sh;       // rx shift register, or tx frame (bits indexed by bitcnt)
    logic [5:0]    bitcnt;   // bit position being received / transmitted
    logic [6:0]    crc;
    logic [CW-1:0] cnt;      // strobes since the command end bit
    logic          tx_end;   // end bit already on the line

    logic [46:0]   frame;    // complete received frame on the end-bit strobe (start bit dropped)
    logic [CW-1:0] cnt_nx;
    logic          tx_bit;
    logic          good;

    assign frame  = {sh[45:0], bus.i_cmd};
    assign cnt_nx = cnt + CW'(1);
    assign good   = (frame[7:1] == crc) && frame[0];

    assign bus.o_rsp_ready = (state == RSPWAIT);
    assign bus.o_busy      = (state != IDLE);

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // Payload bits come from sh, then the running CRC is shifted out MSB first, then the end bit.
    always_comb begin
        tx_bit = 1'b1;
        if (bitcnt >= 6'd8)
            tx_bit = sh[bitcnt];
        else if (bitcnt != 6'd0)
            tx_bit = crc[6];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state            <= IDLE;
            bus.o_cmd_oe     <= 1'b0;
            bus.o_cmd        <= 1'b1;
            bus.o_cmd_valid  <= 1'b0;
            bus.o_cmd_idx    <= '0;
            bus.o_cmd_arg    <= '0;
            bus.o_cmd_crcerr <= 1'b0;
            bus.o_rsp_drop   <= 1'b0;
            sh               <= '0;
            bitcnt           <= '0;
            crc              <= '0;
            cnt              <= '0;
            tx_end           <= 1'b0;
        end else begin
            bus.o_cmd_valid <= 1'b0;
            bus.o_rsp_drop  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_ck_en && !bus.i_cmd) begin
                        state  <= RXCMD;
                        bitcnt <= 6'd46;
                        crc    <= '0;
                        sh     <= '0;
                    end
                end
                RXCMD: begin
                    if (bus.i_ck_en) begin
                        sh <= {sh[46:0], bus.i_cmd};
                        if (bitcnt >= 6'd8)
                            crc <= crc7_step(crc, bus.i_cmd);
                        if (bitcnt == 6'd0) begin
                            cnt <= '0;
                            if (!frame[46]) begin
                                // card-originated frame: not for us
                                state <= IDLE;
                            end else begin
                                bus.o_cmd_valid  <= 1'b1;
                                bus.o_cmd_idx    <= frame[45:40];
                                bus.o_cmd_arg    <= frame[39:8];
                                bus.o_cmd_crcerr <= !good;
                                state            <= good ? RSPWAIT : IDLE;
                            end
                        end else begin
                            bitcnt <= bitcnt - 6'd1;
                        end
                    end
                end
                RSPWAIT: begin
                    if (bus.i_ck_en)
                        cnt <= cnt_nx;
                    // a handshake wins over a timeout landing in the same cycle
                    if (bus.i_rsp_valid) begin
                        if (bus.i_rsp_none) begin
                            state <= IDLE;
                        end else begin
                            sh    <= {2'b00, bus.i_rsp_idx, bus.i_rsp_arg, 8'h01};
                            state <= GAP;
                        end
                    end else if (bus.i_ck_en && cnt_nx == MAX_C) begin
                        bus.o_rsp_drop <= 1'b1;
                        state          <= IDLE;
                    end
                end
                GAP: begin
                    if (bus.i_ck_en) begin
                        // >= covers a handshake that arrived after strobe NCR-1
                        if (cnt_nx >= NCR_C) begin
                            state        <= TXRSP;
                            bus.o_cmd_oe <= 1'b1;
                            bus.o_cmd    <= 1'b0;
                            bitcnt       <= 6'd46;
                            crc          <= '0;
                            tx_end       <= 1'b0;
                        end else begin
                            cnt <= cnt_nx;
                        end
                    end
                end
                TXRSP: begin
                    if (bus.i_ck_en) begin
                        if (tx_end) begin
                            bus.o_cmd_oe <= 1'b0;
                            bus.o_cmd    <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            bus.o_cmd <= tx_bit;
                            if (bitcnt >= 6'd8)
                                crc <= crc7_step(crc, tx_bit);
                            else
                                crc <= {crc[5:0], 1'b0};
                            if (bitcnt == 6'd0)
                                tx_end <= 1'b1;
                            else
                                bitcnt <= bitcnt - 6'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
